dmem_access_unit: RTL
=====================

# dmem_access_unit

Multi-cycle load/store initiator between the MIPS pipeline's memory stage and the word-organised data memory. It accepts one byte, halfword or word load/store request at a time. It drives the DMEM address, data, read-strobe and write-strobe signals from flops. It performs read-modify-write for sub-word stores, then returns sign- or zero-extended load data, or a misalignment error, as a one-cycle response pulse.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits used. DMEM depth is 2^ADDR_WIDTH words.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present; sampled only while `req_ready`=1.
- `req_ready` output 1: unit idle and able to accept.
- `req_store` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` input 1: zero-extend the load result (LBU/LHU). Ignored for stores and words.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `resp_valid` output 1: one-cycle completion pulse. No backpressure.
- `resp_err` output 1: valid with `resp_valid`; misaligned or illegal size.
- `resp_rdata` output 32: extended load data. 0 for stores and errors.
- `DMEM_address` output 32: word index, {zeros, req_addr[ADDR_WIDTH+1:2]}.
- `DMEM_data_in` output 32: write word to DMEM.
- `DMEM_mem_write` output 1: DMEM write strobe (level).
- `DMEM_mem_read` output 1: DMEM read strobe (level).
- `DMEM_data_out` input 32: DMEM read word, combinational from address and strobe.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP, ERR.
- IDLE: `req_ready`=1. The request is accepted at an edge where `req_valid`=1. At acceptance, latch addr, size, unsigned and wdata, and load the DMEM_address register.
- Alignment check at accept:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Size 11 is always illegal.
  - A failed check goes to ERR with no DMEM strobe ever asserted.
- Load, word or sub-word: IDLE→LOAD→RESP.
  - In LOAD, `DMEM_mem_read`=1 and `DMEM_data_out` is captured at the end of the cycle.
- Word store: IDLE→STORE→RESP.
  - In STORE, `DMEM_mem_write`=1 and `DMEM_data_in`=wdata.
- Byte or halfword store: IDLE→RMW_RD→RMW_WR→RESP.
  - RMW_RD reads and captures the old word.
  - RMW_WR writes the merged word: only the target lanes are replaced, with wdata[7:0] or wdata[15:0].
- Byte lanes are little-endian:
  - Byte offset k occupies bits [8k+7:8k].
  - Halfword at offset 0 occupies [15:0]; at offset 2, [31:16].
- Load extraction selects the lane, then sign-extends from bit 7/15. Zero-extends if unsigned.
- RESP: `resp_valid`=1, `resp_err`=0 → IDLE. ERR: `resp_valid`=1, `resp_err`=1, `resp_rdata`=0 → IDLE.
- `DMEM_mem_read` and `DMEM_mem_write` are never 1 in the same cycle. Both are 0 in IDLE, RESP and ERR.
- Upper address bits above ADDR_WIDTH+1 are ignored (wrap), with no error.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `DMEM_mem_read`=0, `DMEM_mem_write`=0.
  - `DMEM_address`=0, `DMEM_data_in`=0.
- All DMEM outputs come directly from flops, with no combinational path from request inputs.
- `DMEM_address` changes only at the accept edge, so it is stable throughout and one cycle beyond every strobe.
- `DMEM_data_in` changes only on the same edge that raises `DMEM_mem_write`. It holds through the edge that drops it.
- Latency from accept edge (cycle 0) to `resp_valid` high:
  - Load: cycle 2.
  - Word store: cycle 2.
  - Sub-word store: cycle 3.
  - Error: cycle 1.
- `req_ready` is low from cycle 1 through the `resp_valid` cycle and high again the cycle after. Back-to-back throughput is therefore 3, 3, 4 or 2 cycles.
- Reset mid-operation:
  - Strobes drop immediately (asynchronous).
  - No response is issued.
  - A reset during RMW_RD leaves memory unmodified.

## Test plan
- Reset → all outputs at reset values listed above; `req_ready`=1. Drop reset, idle 5 cycles → no strobes.
- Preload word 3 = 0x8899AABB.
  - LB 0xD → rdata 0xFFFFFFAA at cycle 2.
  - LBU 0xD → 0x000000AA.
  - LH 0xE → 0xFFFF8899.
  - LHU 0xC → 0x0000AABB.
- SW 0x11223344 to 0x10, then LW 0x10 → write strobe exactly 1 cycle with DMEM_address=4; read returns 0x11223344, err=0.
- Word 3 = 0x8899AABB.
  - SH wdata 0x00001234 at 0xE → read then write; word 3 = 0x1234AABB; resp at cycle 3.
  - SB 0x55 at 0xC → 0x1234AA55.
- LW 0x6, SH 0x5, size 11 at 0x0 → resp_valid with err=1 at cycle 1, rdata=0, no DMEM strobes.
- Assert `rst_n`=0 during RMW_RD of SB to 0x8 (word 2 = 0xCAFEBABE) → strobes 0 immediately, no resp_valid, word 2 unchanged, `req_ready`=1 after release.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Multi-cycle load/store initiator for a word-organised data memory.
// Sub-word stores are done as read-modify-write; all DMEM outputs come straight from flops.
module dmem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStore,
    StRmwRd,
    StRmwWr,
    StResp,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_in_q, data_in_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  logic        misaligned;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        unused_addr;

  // Address bits above the implemented depth wrap silently.
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    lane_b   = DMEM_data_out[{off_q, 3'b000} +: 8];
    lane_h   = off_q[1] ? DMEM_data_out[31:16] : DMEM_data_out[15:0];
    load_ext = DMEM_data_out;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = DMEM_data_out;
    endcase
  end

  // Replace only the target lanes of the old word.
  always_comb begin
    merged = DMEM_data_out;
    if (size_q == 2'b00) begin
      merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    data_in_d = data_in_q;
    rdata_d   = rdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          off_d   = req_addr[1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          addr_d  = {{(32 - ADDR_WIDTH){1'b0}}, req_addr[ADDR_WIDTH+1:2]};
          rdata_d = 32'h0;
          if (misaligned) begin
            state_d = StErr;
          end else if (!req_store) begin
            state_d = StLoad;
            rd_d    = 1'b1;
          end else if (req_size == 2'b10) begin
            state_d   = StStore;
            wr_d      = 1'b1;
            data_in_d = req_wdata;
          end else begin
            state_d = StRmwRd;
            rd_d    = 1'b1;
          end
        end
      end
      StLoad: begin
        rd_d    = 1'b0;
        rdata_d = load_ext;
        state_d = StResp;
      end
      StStore: begin
        wr_d    = 1'b0;
        state_d = StResp;
      end
      StRmwRd: begin
        rd_d      = 1'b0;
        wr_d      = 1'b1;
        data_in_d = merged;
        state_d   = StRmwWr;
      end
      StRmwWr: begin
        wr_d    = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        rdata_d = 32'h0;
        state_d = StIdle;
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wdata_q   <= 32'h0;
      addr_q    <= 32'h0;
      data_in_q <= 32'h0;
      rdata_q   <= 32'h0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      data_in_q <= data_in_d;
      rdata_q   <= rdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign resp_valid     = (state_q == StResp) || (state_q == StErr);
  assign resp_err       = (state_q == StErr);
  assign resp_rdata     = rdata_q;
  assign DMEM_address   = addr_q;
  assign DMEM_data_in   = data_in_q;
  assign DMEM_mem_read  = rd_q;
  assign DMEM_mem_write = wr_q;

endmodule
